// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0]  WIDTH_1B     = 3'b001;
  localparam logic [2:0]  WIDTH_2B     = 3'b010;
  localparam logic [2:0]  WIDTH_4B     = 3'b100;
  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ST   = 2'd1,
    OWN_LB   = 2'd2,
    OWN_IF   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // One-hot width to byte count; the widest set bit wins, zero means no request.
  function automatic logic [CNT_W-1:0] width_bytes(input logic [2:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    if ((w & WIDTH_4B) != 3'b000)      n = CNT_W'(4);
    else if ((w & WIDTH_2B) != 3'b000) n = CNT_W'(2);
    else if ((w & WIDTH_1B) != 3'b000) n = CNT_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_assembler.sv
// Merges little-endian read bytes into a 32-bit word; word_c shows the word with the current byte applied.
module mem_port_arbiter_byte_assembler
  import mem_port_arbiter_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                en,
  input  logic                clr,
  input  logic                we,
  input  logic [1:0]          idx,
  input  logic [BYTE_W-1:0]   din,
  output logic [WORD_W-1:0]   word_c
);

  logic [WORD_W-1:0] word_q;

  always_comb begin
    word_c = word_q;
    word_c[{idx, 3'b000} +: BYTE_W] = din;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_q <= '0;
    end else if (en) begin
      if (clr)     word_q <= '0;
      else if (we) word_q <= word_c;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences ST/LB/IF accesses onto a single byte-wide RAM port.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates LB/IF priority; default is fixed ST > LB > IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              io_buffer_full_in,
  input  logic              st_en_in,
  input  logic [ADDR_W-1:0] st_addr_in,
  input  logic [2:0]        st_width_in,
  input  logic [DATA_W-1:0] st_data_in,
  output logic              st_done_out,
  input  logic              lb_en_in,
  input  logic [ADDR_W-1:0] lb_addr_in,
  input  logic [2:0]        lb_width_in,
  output logic              lb_done_out,
  output logic [DATA_W-1:0] lb_data_out,
  input  logic              if_en_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [DATA_W-1:0] if_data_out,
  input  logic [7:0]        mem_din_in,
  output logic [7:0]        mem_dout_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out
);

  state_e            state_q, state_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_a_q, mem_a_d;
  logic [CNT_W-1:0]  n_q, n_d, k_q, k_d, k_inc;
  logic [WORD_W-1:0] wdata_q, wdata_d, asm_word_c;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              wr_q, wr_d;
  logic              st_done_q, st_done_d, lb_done_q, lb_done_d, if_done_q, if_done_d;
  logic [DATA_W-1:0] lb_data_q, lb_data_d, if_data_q, if_data_d;
  logic [CNT_W-1:0]  st_n, lb_n;
  logic              st_req, lb_req, if_req, lb_pick, can_grant;
  logic              grant_st, grant_lb, grant_if;
  logic              asm_clr, asm_we, io_hit, stall_c;

  assign st_n   = width_bytes(st_width_in);
  assign lb_n   = width_bytes(lb_width_in);
  assign st_req = st_en_in && (st_n != '0);
  assign lb_req = lb_en_in && (lb_n != '0) && !flush_in;
  assign if_req = if_en_in && !flush_in;
  assign k_inc  = k_q + CNT_W'(1);

  // Nothing is granted in the cycle a done pulse is visible to the requesters.
  assign can_grant = (state_q == S_IDLE) && !(st_done_q || lb_done_q || if_done_q);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_lb_q, rr_lb_d;

  assign lb_pick = lb_req && (!if_req || rr_lb_q);

  always_comb begin
    rr_lb_d = rr_lb_q;
    if (grant_lb)      rr_lb_d = 1'b0;
    else if (grant_if) rr_lb_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   rr_lb_q <= 1'b1;
    else if (rdy_in) rr_lb_q <= rr_lb_d;
  end
`else
  assign lb_pick = lb_req;
`endif

  assign grant_st = can_grant && st_req;
  assign grant_lb = can_grant && !st_req && lb_pick;
  assign grant_if = can_grant && !st_req && !lb_pick && if_req;

  // Writes to a full UART buffer wait with the byte held on the pins.
  assign io_hit  = (mem_a_q[17:16] == IO_BASE[17:16]);
  assign stall_c = wr_q && io_hit && io_buffer_full_in;

  mem_port_arbiter_byte_assembler u_asm (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (rdy_in),
    .clr      (asm_clr),
    .we       (asm_we),
    .idx      (2'(k_q - CNT_W'(1))),
    .din      (mem_din_in),
    .word_c   (asm_word_c)
  );

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    base_d     = base_q;
    n_d        = n_q;
    k_d        = k_q;
    wdata_d    = wdata_q;
    mem_a_d    = '0;
    mem_dout_d = '0;
    wr_d       = 1'b0;
    st_done_d  = 1'b0;
    lb_done_d  = 1'b0;
    if_done_d  = 1'b0;
    lb_data_d  = lb_data_q;
    if_data_d  = if_data_q;
    asm_clr    = 1'b0;
    asm_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_st) begin
          state_d    = S_WRITE;
          own_d      = OWN_ST;
          base_d     = st_addr_in;
          n_d        = st_n;
          k_d        = '0;
          wdata_d    = WORD_W'(st_data_in);
          mem_a_d    = st_addr_in;
          mem_dout_d = st_data_in[7:0];
          wr_d       = 1'b1;
        end else if (grant_lb || grant_if) begin
          state_d = S_READ;
          own_d   = grant_lb ? OWN_LB : OWN_IF;
          base_d  = grant_lb ? lb_addr_in : if_addr_in;
          n_d     = grant_lb ? lb_n : CNT_W'(4);
          k_d     = '0;
          mem_a_d = grant_lb ? lb_addr_in : if_addr_in;
          asm_clr = 1'b1;
        end
      end

      // Cycle k drives byte k's address and captures byte k-1; cycle N finishes.
      S_READ: begin
        if (flush_in) begin
          state_d = S_IDLE;
          own_d   = OWN_NONE;
          k_d     = '0;
        end else begin
          k_d    = k_inc;
          asm_we = (k_q != '0);
          if (k_q == n_q) begin
            state_d   = S_IDLE;
            own_d     = OWN_NONE;
            k_d       = '0;
            lb_done_d = (own_q == OWN_LB);
            if_done_d = (own_q == OWN_IF);
            if (own_q == OWN_LB) lb_data_d = DATA_W'(asm_word_c);
            else                 if_data_d = DATA_W'(asm_word_c);
          end else if (k_inc < n_q) begin
            mem_a_d = base_q + ADDR_W'(k_inc);
          end
        end
      end

      S_WRITE: begin
        if (k_q == n_q) begin
          state_d   = S_IDLE;
          own_d     = OWN_NONE;
          k_d       = '0;
          st_done_d = 1'b1;
        end else if (stall_c) begin
          mem_a_d    = mem_a_q;
          mem_dout_d = mem_dout_q;
          wr_d       = 1'b1;
        end else begin
          k_d = k_inc;
          if (k_inc < n_q) begin
            mem_a_d    = base_q + ADDR_W'(k_inc);
            mem_dout_d = 8'(wdata_q >> {k_inc[1:0], 3'b000});
            wr_d       = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        own_d   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      own_q      <= OWN_NONE;
      base_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= 1'b0;
      st_done_q  <= 1'b0;
      lb_done_q  <= 1'b0;
      if_done_q  <= 1'b0;
      lb_data_q  <= '0;
      if_data_q  <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      own_q      <= own_d;
      base_q     <= base_d;
      n_q        <= n_d;
      k_q        <= k_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
      st_done_q  <= st_done_d;
      lb_done_q  <= lb_done_d;
      if_done_q  <= if_done_d;
      lb_data_q  <= lb_data_d;
      if_data_q  <= if_data_d;
    end
  end

  assign mem_a_out    = mem_a_q;
  assign mem_dout_out = mem_dout_q;
  assign mem_wr_out   = wr_q && rdy_in && !stall_c;
  assign st_done_out  = st_done_q;
  assign lb_done_out  = lb_done_q;
  assign if_done_out  = if_done_q;
  assign lb_data_out  = lb_data_q;
  assign if_data_out  = if_data_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single byte-wide RAM port among three requesters: ROB store commit, load buffer, and instruction fetch. Each request is a 1/2/4-byte access that the block splits into per-byte RAM cycles, assembling little-endian read data. A one-cycle `done` pulse returns the result. The block sits between the core's memory clients and the top-level `mem_*` pins, and replaces direct RAM access by the datactrl path.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, requester data width (max access 4 bytes)
- IO_BASE, 32'h30000, start of I/O region; addresses with `addr[17:16]==2'b11` are I/O

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state, forces `mem_wr_out=0`
- flush_in  input  1  ROB misprediction flush (one-cycle pulse)
- io_buffer_full_in  input  1  UART TX buffer full
- st_en_in  input  1  store request (ROB head)
- st_addr_in  input  ADDR_W  store address
- st_width_in  input  3  one-hot width: 001=1B, 010=2B, 100=4B
- st_data_in  input  DATA_W  store data, low bytes used
- st_done_out  output  1  store complete pulse
- lb_en_in  input  1  load request
- lb_addr_in  input  ADDR_W  load address
- lb_width_in  input  3  one-hot width
- lb_done_out  output  1  load complete pulse
- lb_data_out  output  DATA_W  zero-extended load data, valid with `lb_done_out`
- if_en_in  input  1  fetch request (always 4 bytes)
- if_addr_in  input  ADDR_W  fetch address
- if_done_out  output  1  fetch complete pulse
- if_data_out  output  DATA_W  instruction word, valid with `if_done_out`
- mem_din_in  input  8  RAM read byte (1-cycle latency)
- mem_dout_out  output  8  RAM write byte
- mem_a_out  output  ADDR_W  RAM byte address
- mem_wr_out  output  1  1 = write

## Operation
- State machine:
  - States: IDLE, READ, WRITE.
  - Latched per transaction: owner (ST/LB/IF), base address, byte count N (1/2/4), byte counter `k`, write data, 32-bit assembly register.
- IDLE grant order: `st_en_in` > `lb_en_in` > `if_en_in`. A grant is never preempted.
  - ST goes to WRITE.
  - LB and IF go to READ.
  - Zero width is treated as no request.
- READ:
  - Cycle j (0..N-1) drives `mem_a_out = base+j`.
  - Byte j arrives on `mem_din_in` in cycle j+1 and is placed at bits [8j+7:8j].
  - In cycle N, the final byte is merged, the owner's done pulses with data, and the state returns to IDLE.
- WRITE:
  - Cycle j drives `mem_a_out = base+j`, `mem_dout_out = data[8j+7:8j]`, `mem_wr_out = 1`.
  - The owner's done pulses in the cycle after the last byte, and the state returns to IDLE.
- I/O write stall: in WRITE, when the address is in the I/O region and `io_buffer_full_in=1`:
  - `mem_wr_out = 0` and `k` holds.
  - Retry each cycle until the buffer is not full.
- Done/request handshake:
  - A requester deasserts `en` combinationally in its done cycle.
  - In the done cycle (returning to IDLE) the arbiter samples nothing. The next grant decision is made the following cycle.
- Flush:
  - In READ owned by LB or IF: abort to IDLE next edge, no done pulse, outputs discarded.
  - In WRITE: ignored; a committed store always completes.
  - Flush in IDLE suppresses LB and IF grants that cycle.
- Outputs not driven by an active transaction:
  - `mem_wr_out = 0`, `mem_a_out = 0`, `mem_dout_out = 0`.
  - Done pulses are 0; data outputs hold their last value.

## Timing
- Reset (async, low): state IDLE, all done outputs 0, data outputs 0, `mem_wr_out = 0`, `mem_a_out = 0`, `mem_dout_out = 0`, owner/counters cleared.
- Latency from grant cycle (first address driven) to done:
  - Read: N+1 cycles (fetch: 5).
  - Write: N+1 cycles, plus one cycle per I/O stall cycle.
- Back-to-back throughput: one idle cycle between transactions (the done cycle plus grant).
- `rdy_in=0` mid-transaction: state, `k` and the assembly register hold. Byte capture resumes correctly because the RAM address is held stable.
- Simultaneous flush and done in the same cycle: the done pulse is suppressed for LB/IF.
- Address wrap at 2^ADDR_W-1 wraps to 0 (modular add).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: LB and IF alternate priority, with the last-served of the two losing the next tie. ST stays highest.
  - Undefined: fixed priority ST > LB > IF.
  - The round-robin pointer resets to favour LB.

## Structure
- Shared package: owner enum (`OWN_NONE`/`OWN_ST`/`OWN_LB`/`OWN_IF`), state enum, width one-hot constants, `IO_BASE`.
- One natural sub-module: `byte_assembler`, which holds the shift/merge of read bytes into a 32-bit word with a clear input. Everything else is inline.

## Test plan
- LB 4-byte read at 0x100, RAM bytes 11,22,33,44 → `lb_done_out` at cycle 5 after grant, `lb_data_out = 32'h44332211`.
- ST, LB and IF requested together → ST granted first; LB granted after ST done; IF last (round-robin: after LB, the next LB/IF tie goes to IF).
- ST 1-byte to 0x30000, data 8'h41, `io_buffer_full_in` high for 3 cycles → `mem_wr_out` low 3 cycles, then one write of 8'h41, `st_done_out` 5 cycles after grant.
- IF read in progress with `flush_in` at byte 2 → no `if_done_out`, IDLE next cycle, subsequent LB 2-byte read of 0xBEEF returns `32'h0000BEEF`.
- ST 2-byte write, flush mid-write → both bytes written, `st_done_out` pulses.
- `rst_n_in` asserted mid-READ, asynchronously → all outputs 0 immediately; after release, IF request completes normally.
